// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter sharing one single-port RAM with burst-limited round-robin
module ram_port_arbiter #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int BURST_MAX          = 4,
    localparam int ADDR_W            = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] ram_in_m,
    output logic [DATA_WIDTH-1:0] ram_out_m,
    output logic                  ram_write_m,
    output logic [ADDR_W-1:0]     ram_data_addr
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    logic             owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rv0_q;
    logic             rv1_q;
    logic             gnt_any;
    logic             gnt_sel;

    // gnt_sel is the granted port; it stays 0 when idle so the RAM sees port 0's address
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
        if (!reset) begin
            if (p0_req && p1_req) begin
                gnt_any = 1'b1;
                gnt_sel = (cnt_q < CNT_MAX) ? owner_q : ~owner_q;
            end else if (p0_req) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b0;
            end else if (p1_req) begin
                gnt_any = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign p0_gnt        = gnt_any && !gnt_sel;
    assign p1_gnt        = gnt_any && gnt_sel;
    assign ram_data_addr = gnt_sel ? p1_addr : p0_addr;
    assign ram_out_m     = gnt_sel ? p1_wdata : p0_wdata;
    assign ram_write_m   = gnt_any && (gnt_sel ? p1_we : p0_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else if (!gnt_any) begin
            cnt_q <= '0;
        end else if (gnt_sel == owner_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            owner_q <= gnt_sel;
            cnt_q   <= CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= p0_req && p0_gnt && !p0_we;
            rv1_q <= p1_req && p1_gnt && !p1_we;
        end
    end

    // A read accepted just before reset must not surface while reset is held
    assign p0_rvalid = rv0_q && !reset;
    assign p1_rvalid = rv1_q && !reset;
    assign rdata     = ram_in_m;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [9:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [15:0] rdata, ram_in_m, ram_out_m;
    logic        ram_write_m;
    logic [9:0]  ram_data_addr;

    int n_checks = 0;
    int n_errors = 0;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .ram_in_m(ram_in_m), .ram_out_m(ram_out_m),
        .ram_write_m(ram_write_m), .ram_data_addr(ram_data_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int fair_pat[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        ram_in_m = '0;
        tick();
        tick();

        // reset holds off both requesters
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1; p1_we = 1'b1;
        p0_addr = 10'h011; p1_addr = 10'h022; p0_wdata = 16'hAAAA; p1_wdata = 16'h5555;
        #1;
        check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
        check("rst_ram_write", 32'(ram_write_m), 32'd0);
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        tick();
        reset = 1'b0;
        #1;

        // continuous contention: four grants each, starting with port 0
        for (int i = 0; i < 12; i++) begin
            check($sformatf("fair_p0_gnt_%0d", i), 32'(p0_gnt), 32'(fair_pat[i] == 0));
            check($sformatf("fair_p1_gnt_%0d", i), 32'(p1_gnt), 32'(fair_pat[i] == 1));
            check($sformatf("fair_addr_%0d", i), 32'(ram_data_addr),
                  (fair_pat[i] == 1) ? 32'h022 : 32'h011);
            check($sformatf("fair_wdata_%0d", i), 32'(ram_out_m),
                  (fair_pat[i] == 1) ? 32'h5555 : 32'hAAAA);
            check($sformatf("fair_we_%0d", i), 32'(ram_write_m), 32'd1);
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        check("idle_ram_write", 32'(ram_write_m), 32'd0);
        check("idle_addr_p0", 32'(ram_data_addr), 32'h011);
        tick();

        // single write from port 1, then lone requester keeps the grant
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'h3FF; p1_wdata = 16'h1234;
        #1;
        check("wr_ram_write", 32'(ram_write_m), 32'd1);
        check("wr_addr", 32'(ram_data_addr), 32'h3FF);
        check("wr_data", 32'(ram_out_m), 32'h1234);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("lone_p1_gnt_%0d", i), 32'(p1_gnt), 32'd1);
            check($sformatf("lone_p0_gnt_%0d", i), 32'(p0_gnt), 32'd0);
            check($sformatf("lone_p1_rvalid_%0d", i), 32'(p1_rvalid), 32'd0);
            tick();
        end
        p1_req = 1'b0;
        tick();

        // port 0 saturates its burst alone; a late port 1 request wins at once
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h033;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("burst_p0_gnt_%0d", i), 32'(p0_gnt), 32'd1);
            tick();
        end
        p1_req = 1'b1;
        #1;
        check("starve_p1_gnt", 32'(p1_gnt), 32'd1);
        check("starve_p0_gnt", 32'(p0_gnt), 32'd0);
        tick();
        p1_req = 1'b0;
        #1;
        check("after_starve_p0_gnt", 32'(p0_gnt), 32'd1);
        p0_req = 1'b0;
        tick();

        // single read with 1-cycle return
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h005;
        #1;
        check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
        check("rd_ram_write", 32'(ram_write_m), 32'd0);
        check("rd_addr", 32'(ram_data_addr), 32'h005);
        check("rd_rvalid_early", 32'(p0_rvalid), 32'd0);
        tick();
        p0_req = 1'b0; ram_in_m = 16'hBEEF;
        #1;
        check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("rd_rdata", 32'(rdata), 32'hBEEF);
        check("rd_p1_rvalid", 32'(p1_rvalid), 32'd0);
        tick();
        check("rd_rvalid_drop", 32'(p0_rvalid), 32'd0);

        // back-to-back reads, then reset lands while the last return is pending
        p0_req = 1'b1; p0_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p0_addr = 10'(i);
            ram_in_m = 16'(16'h0100 + i);
            #1;
            check($sformatf("b2b_gnt_%0d", i), 32'(p0_gnt), 32'd1);
            check($sformatf("b2b_rvalid_%0d", i), 32'(p0_rvalid), 32'(i > 0));
            tick();
        end
        reset = 1'b1;
        #1;
        check("mid_rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("mid_rst_p0_gnt", 32'(p0_gnt), 32'd0);
        tick();
        reset = 1'b0; p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b1; p1_we = 1'b1;
        #1;
        check("post_rst_p0_gnt", 32'(p0_gnt), 32'd1);
        check("post_rst_p1_gnt", 32'(p1_gnt), 32'd0);
        check("post_rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
